vec_chk_engine: RTL and testbench
=================================

VEC_CHK_ENGINE -- requirements
Module: vec_chk_engine

Interface
REQ-001 Parameters SHALL be: STIM_W, default 49, stimulus vector width; RESP_W, default 25, response width; DEPTH, default 1500, vector entries; LAT, default 1 (range 1..8), DUT response latency in clocks; ADDR_W, default $clog2(DEPTH), derived.
REQ-002 clk input 1: single clock, all logic on rising edge.
REQ-003 rst input 1: reset, synchronous, active-high.
REQ-004 ld_en input 1: write one vector pair to ld_addr.
REQ-005 ld_addr input ADDR_W: load address.
REQ-006 ld_stim input STIM_W and ld_resp input RESP_W: stimulus and expected response to store.
REQ-007 start input 1: begin a run; vec_cnt input ADDR_W+1: vectors to run (0..DEPTH).
REQ-008 stop_on_fail input 1: stop at the first mismatch; cmp_mask input RESP_W: 1 = compare this bit.
REQ-009 abort input 1: cancel the run.
REQ-010 stim_out output STIM_W, registered, drives the DUT; dut_resp input RESP_W, DUT outputs.
REQ-011 busy, done, pass outputs 1 each: status.
REQ-012 err_cnt output 16: mismatch count; first_err_idx output ADDR_W; first_err_act and first_err_exp outputs RESP_W each.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE SHALL move to RUN on start with vec_cnt>0, and to DONE with pass=1 and err_cnt=0 on start with vec_cnt==0.
REQ-015 In RUN, stim_out SHALL present stim[i] for exactly one cycle, i = 0..vec_cnt-1, on consecutive cycles; the first vector appears the cycle after start is sampled.
REQ-016 dut_resp for vector i SHALL be sampled LAT cycles after stim_out first shows stim[i], and compared with resp[i] via a LAT-stage pipeline carrying valid, index and expected value.
REQ-017 A mismatch SHALL be ((dut_resp ^ exp) & cmp_mask) != 0.
REQ-018 After the last vector is issued, the FSM SHALL enter DRAIN, stay LAT cycles, then enter DONE.
REQ-019 In DONE: done=1, busy=0, and pass=1 iff err_cnt==0; the FSM holds DONE until the next start, which clears all results.
REQ-020 busy SHALL be 1 in RUN and DRAIN only.
REQ-021 Each mismatch SHALL increment err_cnt, saturating at 16'hFFFF.
REQ-022 first_err_* SHALL capture only the first mismatch of a run.
REQ-023 stop_on_fail=1: on the first mismatch, the FSM SHALL go directly to DONE on the next edge; in-flight pipeline entries are discarded and err_cnt=1.
REQ-024 abort in RUN or DRAIN SHALL return to IDLE on the next edge, with done=0 and pipeline valids cleared; results are held.
REQ-025 ld_en SHALL be ignored while busy; an ld_en write to an address on the same edge as start SHALL take effect before that address is read.
REQ-026 start while busy SHALL be ignored.
REQ-027 vec_cnt > DEPTH SHALL be clamped to DEPTH.
REQ-028 stim_out SHALL hold its last value in IDLE, DRAIN and DONE.

Reset
REQ-029 rst SHALL force IDLE, stim_out=0, busy=0, done=0, pass=0, err_cnt=0, first_err_*=0 and all pipeline valids=0, including when asserted mid-run.
REQ-030 Vector memory contents SHALL be unaffected by rst.

Structure
REQ-031 Package vec_chk_pkg SHALL hold the state enum typedef, the ERR_CNT_W=16 constant and the LAT_MAX=8 constant.
REQ-032 The LAT-stage valid/index/expected delay line SHALL be sub-module vec_chk_dly.
REQ-033 Memories SHALL be inferred arrays, one write port and one read port each.

Verification
REQ-034 Load 4 vectors with a DUT model that matches all; start, vec_cnt=4, LAT=1 -> done after 1+4+1 cycles, pass=1, err_cnt=0.
REQ-035 resp[2] bit0 wrong, stop_on_fail=0, vec_cnt=4 -> err_cnt=1, first_err_idx=2, first_err_act/first_err_exp differ in bit0.
REQ-036 Same as REQ-035 with stop_on_fail=1 and resp[3] also wrong -> DONE the edge after idx2 is compared, err_cnt=1.
REQ-037 Same as REQ-035 with cmp_mask bit0=0 -> pass=1.
REQ-038 vec_cnt=0 -> DONE next edge, pass=1; abort at vector 2 -> IDLE with done=0.
REQ-039 rst asserted mid-run with LAT=3 -> all outputs 0 and IDLE the next cycle; a subsequent run passes.

Source files
------------

// File: rtl/vec_chk_pkg.sv
// Shared definitions for the vector checker engine.
//   state_t    : run-control FSM states
//   ERR_CNT_W  : width of the saturating mismatch counter
//   LAT_MAX    : largest supported DUT response latency
package vec_chk_pkg;

  localparam int ERR_CNT_W = 16;
  localparam int LAT_MAX   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/vec_chk_dly.sv
// LAT-stage delay line that carries valid, vector index and expected
// response from the cycle a stimulus is issued to the cycle its DUT
// response is sampled.
//   clk, rst          : clock, synchronous active-high reset (valids only)
//   clr               : drop every in-flight entry
//   in_vld/idx/exp    : entry launched alongside stim_out
//   out_vld/idx/exp   : entry arriving at the compare point
module vec_chk_dly #(
  parameter int LAT    = 1,
  parameter int ADDR_W = 4,
  parameter int RESP_W = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_idx,
  input  logic [RESP_W-1:0] in_exp,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_idx,
  output logic [RESP_W-1:0] out_exp
);

  logic              vld_p [LAT];
  logic [ADDR_W-1:0] idx_p [LAT];
  logic [RESP_W-1:0] exp_p [LAT];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int s = 0; s < LAT; s++) vld_p[s] <= 1'b0;
    end else begin
      vld_p[0] <= in_vld;
      for (int s = 1; s < LAT; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // payload stages carry no reset; only the valid bits qualify them
  always_ff @(posedge clk) begin
    idx_p[0] <= in_idx;
    exp_p[0] <= in_exp;
    for (int s = 1; s < LAT; s++) begin
      idx_p[s] <= idx_p[s-1];
      exp_p[s] <= exp_p[s-1];
    end
  end

  assign out_vld = vld_p[LAT-1];
  assign out_idx = idx_p[LAT-1];
  assign out_exp = exp_p[LAT-1];

endmodule

// File: rtl/vec_chk_engine.sv
// Vector checker: stores stimulus/expected-response pairs, plays the
// stimuli to a device under test one per cycle and compares the device
// responses LAT cycles later under a bit mask.
//   clk, rst                 : clock, synchronous active-high reset
//   ld_en/ld_addr/ld_stim/ld_resp : vector memory write port (ignored while busy)
//   start, vec_cnt           : launch a run of vec_cnt vectors (clamped to DEPTH)
//   stop_on_fail, cmp_mask   : stop at first mismatch; per-bit compare enable
//   abort                    : cancel a run, results held
//   stim_out, dut_resp       : stimulus to the device, response from it
//   busy, done, pass         : status
//   err_cnt, first_err_*     : saturating mismatch count, first mismatch details
module vec_chk_engine
  import vec_chk_pkg::*;
#(
  parameter int STIM_W = 49,
  parameter int RESP_W = 25,
  parameter int DEPTH  = 1500,
  parameter int LAT    = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_en,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [STIM_W-1:0]    ld_stim,
  input  logic [RESP_W-1:0]    ld_resp,
  input  logic                 start,
  input  logic [ADDR_W:0]      vec_cnt,
  input  logic                 stop_on_fail,
  input  logic [RESP_W-1:0]    cmp_mask,
  input  logic                 abort,
  output logic [STIM_W-1:0]    stim_out,
  input  logic [RESP_W-1:0]    dut_resp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    first_err_idx,
  output logic [RESP_W-1:0]    first_err_act,
  output logic [RESP_W-1:0]    first_err_exp
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DRN_W = $clog2(LAT_MAX) + 1;

  state_t state, state_nxt;

  logic [STIM_W-1:0] stim_mem [DEPTH];
  logic [RESP_W-1:0] resp_mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  run_cnt;
  logic [DRN_W-1:0]  drain_cnt;

  logic issue, clr_pipe, run_init;
  logic last_idx, drain_last;
  logic cmp_en, mismatch, stop_hit;

  logic              tail_vld;
  logic [ADDR_W-1:0] tail_idx;
  logic [RESP_W-1:0] tail_exp;

  // A write landing on the start edge is visible because the first read
  // of the memory happens one edge later, when RUN issues vector 0.
  always_ff @(posedge clk) begin
    if (ld_en && !busy && ({1'b0, ld_addr} < CNT_W'(DEPTH))) begin
      stim_mem[ld_addr] <= ld_stim;
      resp_mem[ld_addr] <= ld_resp;
    end
  end

  assign last_idx   = ({1'b0, idx} == (run_cnt - CNT_W'(1)));
  assign drain_last = (drain_cnt == DRN_W'(LAT - 1));
  assign cmp_en     = tail_vld && busy && !abort;
  assign mismatch   = cmp_en && (|((dut_resp ^ tail_exp) & cmp_mask));
  assign stop_hit   = mismatch && stop_on_fail;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    clr_pipe  = 1'b0;
    run_init  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        pass = (state == ST_DONE) && (err_cnt == '0);
        if (start) begin
          run_init  = 1'b1;
          state_nxt = (vec_cnt == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort) begin
          clr_pipe  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (stop_hit) begin
          clr_pipe  = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          issue = 1'b1;
          if (last_idx) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (abort) begin
          clr_pipe  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (stop_hit) begin
          clr_pipe  = 1'b1;
          state_nxt = ST_DONE;
        end else if (drain_last) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      run_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (run_init) begin
        idx     <= '0;
        run_cnt <= (vec_cnt > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : vec_cnt;
      end else if (issue) begin
        idx <= idx + ADDR_W'(1);
      end
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DRN_W'(1) : '0;
    end
  end

  // issue stage: stimulus register toward the device
  always_ff @(posedge clk) begin
    if (rst)        stim_out <= '0;
    else if (issue) stim_out <= stim_mem[idx];
  end

  vec_chk_dly #(
    .LAT    (LAT),
    .ADDR_W (ADDR_W),
    .RESP_W (RESP_W)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_pipe),
    .in_vld  (issue),
    .in_idx  (idx),
    .in_exp  (resp_mem[idx]),
    .out_vld (tail_vld),
    .out_idx (tail_idx),
    .out_exp (tail_exp)
  );

  // compare stage: device response meets the delayed expectation
  always_ff @(posedge clk) begin
    if (rst || run_init) begin
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_act <= '0;
      first_err_exp <= '0;
    end else if (mismatch) begin
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
      if (err_cnt == '0) begin
        first_err_idx <= tail_idx;
        first_err_act <= dut_resp;
        first_err_exp <= tail_exp;
      end
    end
  end

endmodule

// File: tb/tb_vec_chk_engine.sv
// Bench for vec_chk_engine: two instances (LAT=1 and LAT=3) share all
// control inputs; each is fed by a behavioural device model of matching
// latency, and results are predicted from the stored vector tables.
module tb_vec_chk_engine;

  localparam int SW = 49;
  localparam int RW = 25;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int CW = 5;

  logic          clk;
  logic          rst, ld_en, start, stop_on_fail, abort;
  logic [AW-1:0] ld_addr;
  logic [SW-1:0] ld_stim;
  logic [RW-1:0] ld_resp, cmp_mask;
  logic [CW-1:0] vec_cnt;

  logic [SW-1:0] stim_out1, stim_out3;
  logic [RW-1:0] dut_resp1, dut_resp3;
  logic          busy1, done1, pass1, busy3, done3, pass3;
  logic [15:0]   err_cnt1, err_cnt3;
  logic [AW-1:0] fei1, fei3;
  logic [RW-1:0] fea1, fee1, fea3, fee3;

  logic [SW-1:0] m_stim [D];
  logic [RW-1:0] m_resp [D];
  logic [SW-1:0] hist3 [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [RW-1:0] ref_dev(input logic [SW-1:0] s);
    return s[RW-1:0] ^ s[SW-1:SW-RW] ^ {s[12:0], s[SW-1:SW-12]};
  endfunction

  function automatic logic [SW-1:0] rnd_stim();
    return {17'($urandom), $urandom};
  endfunction

  // device models: LAT=1 answers combinationally, LAT=3 through two registers
  assign dut_resp1 = ref_dev(stim_out1);
  always @(posedge clk) begin
    hist3[0] <= stim_out3;
    hist3[1] <= hist3[0];
  end
  assign dut_resp3 = ref_dev(hist3[1]);

  vec_chk_engine #(.STIM_W(SW), .RESP_W(RW), .DEPTH(D), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_stim(ld_stim),
    .ld_resp(ld_resp), .start(start), .vec_cnt(vec_cnt), .stop_on_fail(stop_on_fail),
    .cmp_mask(cmp_mask), .abort(abort), .stim_out(stim_out1), .dut_resp(dut_resp1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
    .first_err_idx(fei1), .first_err_act(fea1), .first_err_exp(fee1));

  vec_chk_engine #(.STIM_W(SW), .RESP_W(RW), .DEPTH(D), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_stim(ld_stim),
    .ld_resp(ld_resp), .start(start), .vec_cnt(vec_cnt), .stop_on_fail(stop_on_fail),
    .cmp_mask(cmp_mask), .abort(abort), .stim_out(stim_out3), .dut_resp(dut_resp3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3),
    .first_err_idx(fei3), .first_err_act(fea3), .first_err_exp(fee3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_stim1"}, 64'(stim_out1), 64'd0);
    check({tag, "_stim3"}, 64'(stim_out3), 64'd0);
    check({tag, "_status1"}, 64'({busy1, done1, pass1}), 64'd0);
    check({tag, "_status3"}, 64'({busy3, done3, pass3}), 64'd0);
    check({tag, "_err1"}, 64'(err_cnt1), 64'd0);
    check({tag, "_err3"}, 64'(err_cnt3), 64'd0);
    check({tag, "_first1"}, 64'({fei1, fea1, fee1}), 64'd0);
    check({tag, "_first3"}, 64'({fei3, fea3, fee3}), 64'd0);
  endtask

  task automatic load(input int a, input logic [SW-1:0] s, input logic [RW-1:0] r);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = AW'(a); ld_stim = s; ld_resp = r;
    @(negedge clk);
    ld_en = 1'b0;
    m_stim[a] = s;
    m_resp[a] = r;
  endtask

  // mismatch count and first failing index over the first ne table entries
  task automatic model(input int ne, input bit stop, input logic [RW-1:0] mask,
                       output int cnt, output int first);
    cnt = 0; first = -1;
    for (int i = 0; i < ne; i++) begin
      if (((ref_dev(m_stim[i]) ^ m_resp[i]) & mask) != '0) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
    if (stop && cnt > 0) cnt = 1;
  endtask

  task automatic chk_inst(input string tag, input int got, input int ke,
                          input logic [15:0] ec, input logic p, input logic b,
                          input logic [AW-1:0] fi, input logic [RW-1:0] fa,
                          input logic [RW-1:0] fe, input int cnt, input int first);
    logic [RW-1:0] xa, xe;
    logic [AW-1:0] xi;
    xa = '0; xe = '0; xi = '0;
    if (first >= 0) begin
      xi = AW'(first); xa = ref_dev(m_stim[first]); xe = m_resp[first];
    end
    check({tag, "_done_cycle"}, 64'(got), 64'(ke));
    check({tag, "_err_cnt"}, 64'(ec), 64'(cnt));
    check({tag, "_pass"}, 64'(p), 64'(cnt == 0));
    check({tag, "_busy"}, 64'(b), 64'd0);
    check({tag, "_first_idx"}, 64'(fi), 64'(xi));
    check({tag, "_first_act"}, 64'(fa), 64'(xa));
    check({tag, "_first_exp"}, 64'(fe), 64'(xe));
  endtask

  task automatic run(input int n, input bit stop, input logic [RW-1:0] mask,
                     input bit poke, input bit ldsame);
    int ne, cnt, first, ke1, ke3, got1, got3;
    logic [SW-1:0] s;
    logic [RW-1:0] r;
    @(negedge clk);
    if (ldsame) begin
      s = rnd_stim();
      r = ref_dev(s) ^ RW'(16);
      ld_en = 1'b1; ld_addr = '0; ld_stim = s; ld_resp = r;
      m_stim[0] = s; m_resp[0] = r;
    end
    start = 1'b1; vec_cnt = CW'(n); stop_on_fail = stop; cmp_mask = mask;
    ne = (n > D) ? D : n;
    model(ne, stop, mask, cnt, first);
    ke1 = (ne == 0) ? 0 : (stop && first >= 0) ? first + 2 : ne + 1;
    ke3 = (ne == 0) ? 0 : (stop && first >= 0) ? first + 4 : ne + 3;
    got1 = -1; got3 = -1;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        start = 1'b0; ld_en = 1'b0;
        check("busy_after_start1", 64'(busy1), 64'(ne > 0));
        check("busy_after_start3", 64'(busy3), 64'(ne > 0));
      end
      if (poke && k == 2) begin start = 1'b1; vec_cnt = CW'(1); end
      if (poke && k == 3) start = 1'b0;
      if (k >= 1 && k <= ne && k < ke1) check("stim1", 64'(stim_out1), 64'(m_stim[k-1]));
      if (k >= 1 && k <= ne && k < ke3) check("stim3", 64'(stim_out3), 64'(m_stim[k-1]));
      if (got1 < 0 && done1) got1 = k;
      if (got3 < 0 && done3) got3 = k;
      if (got1 >= 0 && got3 >= 0) break;
    end
    chk_inst("lat1", got1, ke1, err_cnt1, pass1, busy1, fei1, fea1, fee1, cnt, first);
    chk_inst("lat3", got3, ke3, err_cnt3, pass3, busy3, fei3, fea3, fee3, cnt, first);
  endtask

  initial begin
    logic [SW-1:0] s;
    logic [RW-1:0] rr;
    int e1, e3;
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_stim = '0; ld_resp = '0;
    start = 1'b0; vec_cnt = '0; stop_on_fail = 1'b0; cmp_mask = '1; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // all-matching table, 4 vectors
    for (int i = 0; i < D; i++) begin
      s = rnd_stim();
      load(i, s, ref_dev(s));
    end
    run(4, 1'b0, '1, 1'b0, 1'b0);

    // vector 2 expected response wrong in bit 0
    load(2, m_stim[2], ref_dev(m_stim[2]) ^ RW'(1));
    run(4, 1'b0, '1, 1'b0, 1'b0);
    // vector 3 also wrong, stop at first failure
    load(3, m_stim[3], ref_dev(m_stim[3]) ^ RW'(1));
    run(4, 1'b1, '1, 1'b0, 1'b0);
    // bit 0 masked off
    run(4, 1'b0, ~RW'(1), 1'b0, 1'b0);
    // empty run
    run(0, 1'b0, '1, 1'b0, 1'b0);
    // count above depth is clamped
    run(20, 1'b0, '1, 1'b0, 1'b0);
    // load on the start edge, plus a start pulse while busy
    run(8, 1'b0, '1, 1'b1, 1'b1);

    // randomised tables, lengths, masks and stop mode
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < D; i++) begin
        s = rnd_stim();
        rr = ref_dev(s);
        if ($urandom_range(0, 3) == 0) rr ^= RW'(1) << $urandom_range(0, RW - 1);
        load(i, s, rr);
      end
      run($urandom_range(1, D), 1'($urandom_range(0, 1)), RW'($urandom) | RW'(1), 1'b0, 1'b0);
    end

    // abort while vector 2 would be issued; write while busy must be dropped
    load(0, m_stim[0], ref_dev(m_stim[0]) ^ RW'(4));
    @(negedge clk);
    start = 1'b1; vec_cnt = CW'(8); stop_on_fail = 1'b0; cmp_mask = '1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = AW'(5); ld_stim = '1; ld_resp = '1;
    @(posedge clk); #1;
    ld_en = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    e1 = 0; e3 = 0;
    for (int i = 0; i < 8; i++) begin
      if ((ref_dev(m_stim[i]) ^ m_resp[i]) != '0) begin
        if (i + 2 <= 2) e1++;
        if (i + 4 <= 2) e3++;
      end
    end
    check("abort_status1", 64'({busy1, done1}), 64'd0);
    check("abort_status3", 64'({busy3, done3}), 64'd0);
    check("abort_err1", 64'(err_cnt1), 64'(e1));
    check("abort_err3", 64'(err_cnt3), 64'(e3));
    check("abort_stim_hold1", 64'(stim_out1), 64'(m_stim[1]));
    repeat (2) @(posedge clk);
    #1;
    check("abort_idle_hold", 64'({busy1, done1, busy3, done3}), 64'd0);
    check("abort_stim_hold3", 64'(stim_out3), 64'(m_stim[1]));
    run(8, 1'b0, '1, 1'b0, 1'b0);

    // reset in the middle of a run, then a clean run from retained memory
    for (int i = 0; i < D; i++) load(i, m_stim[i], ref_dev(m_stim[i]));
    load(0, m_stim[0], ref_dev(m_stim[0]) ^ RW'(2));
    @(negedge clk);
    start = 1'b1; vec_cnt = CW'(8); stop_on_fail = 1'b0; cmp_mask = '1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero("midrun_rst");
    rst = 1'b0;
    load(0, m_stim[0], ref_dev(m_stim[0]));
    run(8, 1'b0, '1, 1'b0, 1'b0);
    check("post_rst_pass1", 64'(pass1), 64'd1);
    check("post_rst_pass3", 64'(pass3), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
